// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: unit indices, default
// widths, the reserved "no tag" label and a modulo-increment helper.
package cdb_arbiter_pkg;

  localparam int UNIT_ALU = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_LS  = 3;

  localparam int CDB_N_REQ   = 4;
  localparam int CDB_LABEL_W = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_CNT_W   = 16;

  // Label value reserved to mean "no tag"; never broadcast.
  localparam int NO_TAG = 0;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// wrapping modulo N.
module cdb_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  always_comb begin
    int idx;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    idx    = 0;
    // Walk from the farthest offset down so the offset nearest ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[PTR_W'(idx)]) begin
        onehot               = '0;
        onehot[PTR_W'(idx)]  = 1'b1;
        index                = PTR_W'(idx);
        any                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one grant per cycle, registered
// broadcast of the winner's label/result, broadcast counter and tag-error flag.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = CDB_N_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int LABEL_W = CDB_LABEL_W,
  parameter int CNT_W   = CDB_CNT_W
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [N_REQ-1:0]         require,
  input  logic [N_REQ*LABEL_W-1:0] labelIn,
  input  logic [N_REQ*DATA_W-1:0]  dataIn,
  output logic [N_REQ-1:0]         requireAC,
  output logic                     BCEN,
  output logic [LABEL_W-1:0]       BClabel,
  output logic [DATA_W-1:0]        BCdata,
  output logic [CNT_W-1:0]         bcCount,
  output logic                     tagErr
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [LABEL_W-1:0] label_arr [N_REQ];
  logic [DATA_W-1:0]  data_arr  [N_REQ];
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   bad_tag;

  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   ptr_next;
  logic               bcen_reg;
  logic [LABEL_W-1:0] label_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               err_reg;

  logic [N_REQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]   pick_index;
  logic               pick_any;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign label_arr[gi] = labelIn[gi*LABEL_W +: LABEL_W];
      assign data_arr[gi]  = dataIn[gi*DATA_W +: DATA_W];
      assign eligible[gi]  = require[gi] && (label_arr[gi] != LABEL_W'(NO_TAG));
      assign bad_tag[gi]   = require[gi] && (label_arr[gi] == LABEL_W'(NO_TAG));
    end
  endgenerate

  cdb_arbiter_rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .onehot   (pick_onehot),
    .index    (pick_index),
    .any      (pick_any)
  );

  // Accept depends only on requests and ptr, never on the broadcast registers.
  assign requireAC = nRST ? pick_onehot : '0;
  assign ptr_next  = PTR_W'(wrap_inc(int'(pick_index), N_REQ));

  always_ff @(posedge clk) begin
    if (!nRST) begin
      ptr_reg   <= '0;
      bcen_reg  <= 1'b0;
      label_reg <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      bcen_reg <= pick_any;
      if (pick_any) begin
        label_reg <= label_arr[pick_index];
        data_reg  <= data_arr[pick_index];
        ptr_reg   <= ptr_next;
        cnt_reg   <= cnt_reg + CNT_W'(1);
      end
      if (|bad_tag) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign BCEN    = bcen_reg;
  assign BClabel = label_reg;
  assign BCdata  = data_reg;
  assign bcCount = cnt_reg;
  assign tagErr  = err_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized + directed bench for cdb_arbiter: a round-robin reference model
// predicts accepts and queues expected broadcasts for a separate monitor.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            nRST;
  logic [N-1:0]    require;
  logic [N*LW-1:0] labelIn;
  logic [N*DW-1:0] dataIn;
  logic [N-1:0]    requireAC;
  logic            BCEN;
  logic [LW-1:0]   BClabel;
  logic [DW-1:0]   BCdata;
  logic [CW-1:0]   bcCount;
  logic            tagErr;

  cdb_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .LABEL_W (LW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .require   (require),
    .labelIn   (labelIn),
    .dataIn    (dataIn),
    .requireAC (requireAC),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .bcCount   (bcCount),
    .tagErr    (tagErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            stamp;
    logic [LW-1:0] lab;
    logic [DW-1:0] dat;
    logic [CW-1:0] cnt;
  } bc_t;

  bc_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  // Requester-side state: what each unit is currently presenting.
  bit   [N-1:0]  pend_req;
  logic [LW-1:0] pend_lab [N];
  logic [DW-1:0] pend_dat [N];

  // Reference model state.
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst_n);
    int g;
    int idx;
    bc_t e;
    @(negedge clk);
    nRST = rst_n;
    require = pend_req;
    for (int i = 0; i < N; i++) begin
      labelIn[i*LW +: LW] = pend_lab[i];
      dataIn[i*DW +: DW]  = pend_dat[i];
    end
    #1;
    chk("bcCount", {60'd0, bcCount}, 64'(m_cnt));
    chk("tagErr", {63'd0, tagErr}, {63'd0, m_err});
    g = -1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && pend_req[idx] && pend_lab[idx] != 0) g = idx;
      end
    end
    chk("requireAC", {60'd0, requireAC}, (g >= 0) ? (64'd1 << g) : 64'd0);
    $display("cycle %0d rst_n=%0b req=%b grant=%0d", cyc + 1, rst_n, pend_req, g);
    if (!rst_n) begin
      m_ptr = 0;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (pend_req[i] && pend_lab[i] == 0) m_err = 1'b1;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        m_cnt = (m_cnt + 1) % (1 << CW);
        e.stamp = cyc + 1;
        e.lab   = pend_lab[g];
        e.dat   = pend_dat[g];
        e.cnt   = CW'(m_cnt);
        exp_q.push_back(e);
        pend_req[g] = 1'b0;
      end
    end
  endtask

  task automatic present(input int u, input logic [LW-1:0] lab, input logic [DW-1:0] dat);
    pend_req[u] = 1'b1;
    pend_lab[u] = lab;
    pend_dat[u] = dat;
  endtask

  // Monitor: every cycle, BCEN must match whether a broadcast is due now.
  initial begin
    bc_t e;
    bit  due;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      due = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
      chk("BCEN", {63'd0, BCEN}, {63'd0, due});
      if (due) begin
        e = exp_q.pop_front();
        if (BCEN) begin
          chk("BClabel", {60'd0, BClabel}, {60'd0, e.lab});
          chk("BCdata", {32'd0, BCdata}, {32'd0, e.dat});
          chk("bcCount_bc", {60'd0, bcCount}, {60'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    nRST = 1'b0;
    require = '0;
    labelIn = '0;
    dataIn = '0;
    pend_req = '0;
    for (int i = 0; i < N; i++) begin
      pend_lab[i] = '0;
      pend_dat[i] = '0;
    end
    repeat (2) @(posedge clk);
    step(1'b0);
    #1;
    chk("BClabel_rst", {60'd0, BClabel}, 64'd0);
    chk("BCdata_rst", {32'd0, BCdata}, 64'd0);

    // Single ALU request.
    present(0, 4'h3, 32'h0000_00AA);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Full contention from ptr=0.
    step(1'b0);
    for (int i = 0; i < N; i++) present(i, LW'(i + 1), $urandom);
    repeat (5) step(1'b1);

    // Rotation: park ptr at div, then alu and ls compete every cycle.
    step(1'b0);
    present(1, 4'h7, 32'h1111_2222);
    step(1'b1);
    for (int i = 0; i < 6; i++) begin
      present(0, LW'((2 * i) % 15 + 1), $urandom);
      present(3, LW'((2 * i + 1) % 15 + 1), $urandom);
      step(1'b1);
    end
    pend_req = '0;
    step(1'b1);

    // Label-0 request alongside a valid one; tagErr sticks until reset.
    step(1'b0);
    present(2, 4'h0, 32'hDEAD_0002);
    present(1, 4'h5, 32'h0000_0055);
    repeat (3) step(1'b1);
    pend_req = '0;
    step(1'b1);
    step(1'b0);
    step(1'b1);

    // Reset landing on a grant cycle.
    for (int i = 0; i < N; i++) present(i, LW'(i + 9), $urandom);
    step(1'b1);
    for (int i = 0; i < N; i++) present(i, LW'(i + 9), $urandom);
    step(1'b0);
    repeat (5) step(1'b1);

    // Counter wrap with a 4-bit counter: 17 broadcasts.
    step(1'b0);
    for (int i = 0; i < 17; i++) begin
      present(0, LW'(i % 15 + 1), $urandom);
      step(1'b1);
    end
    step(1'b1);

    // Randomized traffic with holds, drops and the occasional reset.
    step(1'b0);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_req[i]) begin
          if ($urandom_range(1, 0) == 1) present(i, LW'($urandom_range(15, 0)), $urandom);
        end else if ($urandom_range(9, 0) == 0) begin
          pend_req[i] = 1'b0;
        end else if (pend_lab[i] == 0 && $urandom_range(2, 0) == 0) begin
          pend_req[i] = 1'b0;
        end
      end
      step($urandom_range(99, 0) != 0);
    end
    pend_req = '0;
    repeat (3) step(1'b1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Schedules the single common data bus (CDB) shared by the result producers: ALU, MUL, DIV and load/store. Each cycle it grants at most one requester using round-robin priority. The granted label/result pair is registered and broadcast to the register file and all reservation stations on BCEN/BClabel/BCdata. It replaces the combinational require/accept helper and adds a registered broadcast, fairness and a broadcast count.

Parameters:
N_REQ, 4, number of requesters; index 3..0 = ls, div, mul, alu
DATA_W, 32, result width
LABEL_W, 4, reservation-station tag width; tag 0 = "no tag"/invalid
CNT_W, 16, width of broadcast counter

Ports:
clk  in  1  clock, all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
require  in  N_REQ  per-unit request to broadcast; held until accepted
labelIn  in  N_REQ*LABEL_W  packed tags, unit i at [i*LABEL_W +: LABEL_W]
dataIn  in  N_REQ*DATA_W  packed results, unit i at [i*DATA_W +: DATA_W]
requireAC  out  N_REQ  one-hot accept, combinational, same cycle as grant
BCEN  out  1  broadcast valid, registered
BClabel  out  LABEL_W  broadcast tag, registered
BCdata  out  DATA_W  broadcast result, registered
bcCount  out  CNT_W  number of broadcasts since reset, wraps
tagErr  out  1  sticky: a request arrived with label 0

Behaviour:
- Reset is synchronous and active-low on clk/nRST.
- Reset values: BCEN=0, BClabel=0, BCdata=0, bcCount=0, tagErr=0, rr pointer=0 (ALU highest priority).
- While nRST=0, requireAC is forced to 0 (combinational gate).
- Eligible[i] = require[i] && labelIn[i] != 0.
- Grant: search from ptr upward, modulo N_REQ. The first eligible index g gets requireAC[g]=1; all other accept bits are 0.
- No eligible requester: requireAC=0 and ptr is unchanged.
- On a grant edge:
  - BCEN<=1, BClabel<=labelIn[g], BCdata<=dataIn[g]
  - ptr<=(g+1) mod N_REQ
  - bcCount<=bcCount+1, wrapping at 2^CNT_W-1 -> 0
- On a non-grant edge: BCEN<=0. BClabel and BCdata hold their last values, and consumers ignore them.
- Latency: request seen in cycle t -> requireAC in cycle t -> BCEN high for exactly cycle t+1. Back-to-back grants give continuous BCEN=1, one broadcast per cycle.
- Requester contract: the unit drops require (or presents its next result) in the cycle after it sees requireAC. The arbiter does not latch requests and takes no action on an un-accepted request.
- Label-0 request: never granted. tagErr<=1 and stays set until reset. Other requesters proceed normally.
- All four requesting: grant order from ptr=0 is alu, mul, div, ls, repeating. Maximum wait for any eligible requester is N_REQ-1 cycles.
- Request dropped before accept: no effect and no state change.
- Reset mid-broadcast: the broadcast registered on that edge is discarded, BCEN=0 the next cycle, and ptr returns to 0.
- No combinational path from BC* to requireAC.

Decomposition:
- Shared package (head.v defines): unit index constants UNIT_ALU=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_LS=3; LABEL_W; DATA_W; NO_TAG=0.
- One natural sub-module: rr_pick, the combinational round-robin one-hot picker (inputs eligible, ptr; outputs onehot, index, any). cdb_arbiter holds ptr, the output registers, the counter and the error flag.

Test Plan:
- Reset then single request: require=0001, labelIn[alu]=4'h3, dataIn[alu]=32'h0000_00AA -> requireAC=0001 same cycle; next cycle BCEN=1, BClabel=3, BCdata=0xAA; bcCount=1; following idle cycle BCEN=0.
- Full contention: all four request with tags 1,2,3,4 and each drops after its accept -> grants alu, mul, div, ls on four consecutive cycles; BCEN high for 4 cycles; BClabel sequence 1,2,3,4; bcCount=4.
- Fairness/rotation: ptr at div after granting mul; alu and ls request continuously with a new tag each cycle -> grants alternate ls, alu, ls, alu; neither waits more than 1 cycle.
- Invalid tag: require=0100 with labelIn[div]=0, plus mul with tag 5 -> only mul accepted; BClabel=5; tagErr=1 and stays 1 after div retries; nRST=0 for one cycle clears it.
- Reset mid-operation: assert nRST=0 in the cycle a grant occurs -> requireAC=0 that cycle; BCEN=0, bcCount=0 next cycle; after release with all requesting, first grant is alu.
- Counter wrap (CNT_W=4): 17 broadcasts -> bcCount counts 1..15, 0, 1.
